// File: rtl/cntr_ud.sv
// Up/down modulo counter with run-time terminal value, parallel load,
// elaboration-time wrap/saturate mode and registered wrap/sticky event flags.
module cntr_ud #(
    parameter int             w   = 8,
    parameter logic [w-1:0]   iv  = '0,
    parameter bit             sat = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [w-1:0] d,
    input  logic [w-1:0] top,
    input  logic         ack,
    output logic [w-1:0] q,
    output logic         at_top,
    output logic         at_zero,
    output logic         wrap,
    output logic         evt
);

    logic         hit;
    logic [w-1:0] q_step;
    logic [w-1:0] q_bound;

    assign at_top  = (q >= top);
    assign at_zero = (q == '0);

    // A boundary hit is decided against the value held now; q above top counts as a hit going up.
    assign hit     = up ? at_top : at_zero;
    assign q_step  = up ? (q + 1'b1) : (q - 1'b1);
    assign q_bound = sat ? q : (up ? '0 : top);

    always_ff @(posedge clk) begin
        if (clr) begin
            q    <= iv;
            wrap <= 1'b0;
            evt  <= 1'b0;
        end else if (ld) begin
            q    <= d;
            wrap <= 1'b0;
            evt  <= 1'b0;
        end else if (en) begin
            if (hit) begin
                q    <= q_bound;
                wrap <= 1'b1;
                evt  <= 1'b1;
            end else begin
                q    <= q_step;
                wrap <= 1'b0;
                evt  <= evt & ~ack;
            end
        end else begin
            wrap <= 1'b0;
            evt  <= evt & ~ack;
        end
    end

endmodule

// File: tb/tb_cntr_ud.sv
// Bench for cntr_ud: a wrap-mode and a saturate-mode instance driven in
// parallel, compared every cycle against an arithmetic reference model.
module tb_cntr_ud;

    localparam int          W      = 8;
    localparam logic [7:0]  IV_A   = 8'd0;
    localparam logic [7:0]  IV_B   = 8'd5;

    logic         clk = 1'b0;
    logic         clr, en, up, ld, ack;
    logic [W-1:0] d, top;
    logic [W-1:0] q_a, q_b;
    logic         at_top_a, at_zero_a, wrap_a, evt_a;
    logic         at_top_b, at_zero_b, wrap_b, evt_b;

    int n_checks = 0;
    int n_fail   = 0;

    int mq[2];
    int mw[2];
    int me[2];
    int m_iv[2];
    int m_sat[2];

    always #5 clk = ~clk;

    cntr_ud #(.w(W), .iv(IV_A), .sat(1'b0)) dut_a (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .d(d), .top(top), .ack(ack),
        .q(q_a), .at_top(at_top_a), .at_zero(at_zero_a), .wrap(wrap_a), .evt(evt_a)
    );

    cntr_ud #(.w(W), .iv(IV_B), .sat(1'b1)) dut_b (
        .clk(clk), .clr(clr), .en(en), .up(up), .ld(ld), .d(d), .top(top), .ack(ack),
        .q(q_b), .at_top(at_top_b), .at_zero(at_zero_b), .wrap(wrap_b), .evt(evt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: next state from the counting rules, using plain integers.
    task automatic model_edge(input int i, input int c_clr, input int c_ld, input int c_en,
                              input int c_up, input int c_d, input int c_top, input int c_ack);
        int hit;
        if (c_clr != 0) begin
            mq[i] = m_iv[i]; mw[i] = 0; me[i] = 0;
        end else if (c_ld != 0) begin
            mq[i] = c_d; mw[i] = 0; me[i] = 0;
        end else if (c_en != 0) begin
            if (c_up != 0) hit = (mq[i] >= c_top) ? 1 : 0;
            else           hit = (mq[i] == 0) ? 1 : 0;
            if (hit == 1) begin
                if (m_sat[i] == 0) mq[i] = (c_up != 0) ? 0 : c_top;
                mw[i] = 1;
                me[i] = 1;
            end else begin
                mq[i] = (c_up != 0) ? mq[i] + 1 : mq[i] - 1;
                mw[i] = 0;
                if (c_ack != 0) me[i] = 0;
            end
        end else begin
            mw[i] = 0;
            if (c_ack != 0) me[i] = 0;
        end
    endtask

    task automatic cyc();
        int c_clr, c_ld, c_en, c_up, c_d, c_top, c_ack;
        c_clr = int'(clr); c_ld = int'(ld); c_en = int'(en); c_up = int'(up);
        c_d = int'(d); c_top = int'(top); c_ack = int'(ack);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, c_clr, c_ld, c_en, c_up, c_d, c_top, c_ack);
        #1;
        check("a.q",       32'(q_a),       32'(mq[0]));
        check("a.wrap",    32'(wrap_a),    32'(mw[0]));
        check("a.evt",     32'(evt_a),     32'(me[0]));
        check("a.at_top",  32'(at_top_a),  (mq[0] >= int'(top)) ? 32'd1 : 32'd0);
        check("a.at_zero", 32'(at_zero_a), (mq[0] == 0) ? 32'd1 : 32'd0);
        check("b.q",       32'(q_b),       32'(mq[1]));
        check("b.wrap",    32'(wrap_b),    32'(mw[1]));
        check("b.evt",     32'(evt_b),     32'(me[1]));
        check("b.at_top",  32'(at_top_b),  (mq[1] >= int'(top)) ? 32'd1 : 32'd0);
        check("b.at_zero", 32'(at_zero_b), (mq[1] == 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int exp_up[7];
        int exp_dn[4];
        int exp_sat[6];
        exp_up  = '{1, 2, 3, 4, 0, 1, 2};
        exp_dn  = '{1, 0, 4, 3};
        exp_sat = '{1, 2, 3, 3, 3, 3};
        m_iv[0] = int'(IV_A); m_iv[1] = int'(IV_B);
        m_sat[0] = 0;         m_sat[1] = 1;

        clr = 1; en = 0; up = 1; ld = 0; ack = 0; d = '0; top = 8'd4;
        #2;
        cyc();
        check("reset.a.q", 32'(q_a), 32'd0);
        check("reset.b.q", 32'(q_b), 32'd5);
        check("reset.b.at_zero", 32'(at_zero_b), 32'd0);

        // wrap-mode count up to top=4
        clr = 0; en = 1; up = 1;
        for (int k = 0; k < 7; k++) begin
            cyc();
            check("up4.q", 32'(q_a), 32'(exp_up[k]));
            check("up4.wrap", 32'(wrap_a), (exp_up[k] == 0) ? 32'd1 : 32'd0);
        end
        en = 0;
        for (int k = 0; k < 2; k++) begin
            cyc();
            check("evt_hold", 32'(evt_a), 32'd1);
        end
        ack = 1; cyc(); ack = 0;
        check("evt_ack", 32'(evt_a), 32'd0);

        // load then count down through zero
        ld = 1; d = 8'd2; cyc(); ld = 0;
        check("ld2.q", 32'(q_a), 32'd2);
        en = 1; up = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("dn.q", 32'(q_a), 32'(exp_dn[k]));
            check("dn.wrap", 32'(wrap_a), (exp_dn[k] == 4) ? 32'd1 : 32'd0);
            check("dn.at_zero", 32'(at_zero_a), (exp_dn[k] == 0) ? 32'd1 : 32'd0);
        end

        // saturate mode, top=3
        top = 8'd3; en = 0; ld = 1; d = 8'd0; cyc(); ld = 0;
        en = 1; up = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("sat.q", 32'(q_b), 32'(exp_sat[k]));
            check("sat.wrap", 32'(wrap_b), (k >= 3) ? 32'd1 : 32'd0);
        end
        up = 0;
        for (int k = 0; k < 6; k++) cyc();
        check("sat.floor", 32'(q_b), 32'd0);
        check("sat.floor.wrap", 32'(wrap_b), 32'd1);

        // priority: clr over ld over en
        clr = 1; ld = 1; en = 1; up = 1; d = 8'd9; cyc();
        check("prio.clr.q", 32'(q_a), 32'(IV_A));
        check("prio.clr.b.q", 32'(q_b), 32'(IV_B));
        check("prio.clr.evt", 32'(evt_a), 32'd0);
        clr = 0; cyc(); ld = 0;
        check("prio.ld.q", 32'(q_a), 32'd9);

        // q above top
        top = 8'd10; en = 0; ld = 1; d = 8'd200; cyc(); ld = 0;
        en = 1; up = 1; cyc();
        check("over.up.q", 32'(q_a), 32'd0);
        check("over.up.wrap", 32'(wrap_a), 32'd1);
        check("over.sat.q", 32'(q_b), 32'd200);
        en = 0; ld = 1; cyc(); ld = 0;
        en = 1; up = 0; cyc();
        check("over.dn.q", 32'(q_a), 32'd199);

        // ack colliding with a wrap: set wins
        en = 0; ld = 1; d = 8'd10; cyc(); ld = 0;
        en = 1; up = 1; cyc();
        check("coll.pre.evt", 32'(evt_a), 32'd1);
        top = 8'd0; ack = 1; cyc();
        check("coll.evt", 32'(evt_a), 32'd1);
        en = 0; cyc(); ack = 0;
        check("coll.clear", 32'(evt_a), 32'd0);

        // top = 0 and full range
        en = 1; up = 1; cyc(); cyc();
        up = 0; cyc();
        check("top0.q", 32'(q_a), 32'd0);
        top = 8'hFF; en = 0; ld = 1; d = 8'hFE; cyc(); ld = 0;
        en = 1; up = 1; cyc();
        check("full.q", 32'(q_a), 32'd255);
        cyc();
        check("full.wrap.q", 32'(q_a), 32'd0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            clr = ($urandom_range(0, 31) == 0);
            ld  = ($urandom_range(0, 7) == 0);
            en  = ($urandom_range(0, 3) != 0);
            up  = $urandom_range(0, 1);
            ack = ($urandom_range(0, 3) == 0);
            d   = W'($urandom);
            case ($urandom_range(0, 9))
                0:       top = 8'd0;
                1:       top = 8'hFF;
                2, 3:    top = W'($urandom);
                default: ;
            endcase
            if (k % 50 == 0) top = W'($urandom_range(1, 12));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
